// File: rtl/rv_pkg.sv
// Shared RV32I definitions: instruction formats, major opcodes, request bundle
// and a sign-extension range helper used by the immediate packer.
package rv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  // True when v[31:top] are all equal, i.e. v sign-extends from bit top.
  function automatic logic fits_signed(logic [31:0] v, int unsigned top);
    logic [31:0] hi;
    hi = $signed(v) >>> top;
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder.
// Handshake: a beat transfers on a rising edge where valid && ready; the
// source holds payload stable while valid is high and ready is low.
interface imm_encoder_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             range_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instr, range_err, err_count
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instr, range_err, err_count
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational RV32I field packer: scatters the immediate into the word for
// the given format and flags immediates the format cannot represent.
module imm_pack
  import rv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  always_comb begin
    word = '0;
    err  = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !fits_signed(imm, 11);
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !fits_signed(imm, 11);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !fits_signed(imm, 12) || imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !fits_signed(imm, 20) || imm[0];
      end
      // Unassigned format codes still emit the opcode so the consumer sees a word.
      default: begin
        word = {25'b0, opcode};
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: S1 holds the request and
// feeds the packer, S2 holds the packed word; counts delivered range errors.
module imm_encoder
  import rv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  imm_encoder_if.slave bus
);

  req_t             s1_req;
  logic             s1_valid;
  logic             s2_valid;
  logic [31:0]      s2_instr;
  logic             s2_err;
  logic [CNT_W-1:0] err_cnt;

  logic        s1_adv;
  logic        accept;
  logic        deliver;
  logic [31:0] pk_word;
  logic        pk_err;

  // S1 may move into S2 whenever S2 is empty or being drained this cycle.
  assign s1_adv      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign accept      = bus.in_valid && bus.in_ready;
  assign deliver     = s2_valid && bus.out_ready;

  imm_pack u_pack (
    .fmt    (s1_req.fmt),
    .opcode (s1_req.opcode),
    .funct3 (s1_req.funct3),
    .funct7 (s1_req.funct7),
    .rd     (s1_req.rd),
    .rs1    (s1_req.rs1),
    .rs2    (s1_req.rs2),
    .imm    (s1_req.imm),
    .word   (pk_word),
    .err    (pk_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_req   <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (accept) begin
        s1_req <= '{fmt: bus.fmt, opcode: bus.opcode, funct3: bus.funct3,
                    funct7: bus.funct7, rd: bus.rd, rs1: bus.rs1, rs2: bus.rs2,
                    imm: bus.imm};
      end
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= pk_word;
          s2_err   <= pk_err;
        end
      end
      if (deliver && s2_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.instr     = s2_instr;
  assign bus.range_err = s2_err;
  assign bus.err_count = err_cnt;

endmodule
